prog_mem_loader: RTL and testbench

PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

---
 rtl/prog_mem_loader.sv | 121 ++++++++++++
 tb/tb_prog_mem_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_loader.sv
// Program memory with a byte-stream image loader. A length-prefixed, XOR-checksummed
// image is written into memory; the core is held in reset until a good image is running.
module prog_mem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_PMADDR,
  output logic [15:0] o_PMDATA,
  input  logic        i_rxValid,
  input  logic [7:0]  i_rxByte,
  output logic        o_rxReady,
  input  logic        i_loadReq,
  output logic        o_coreReset,
  output logic        o_loadDone,
  output logic        o_loadError
);

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [16:0] DEPTH17 = 17'(DEPTH);

  typedef enum logic [2:0] {
    LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK, RUN, ERROR
  } state_e;

  logic [15:0] mem [DEPTH];

  state_e          state_q, state_d;
  logic [15:0]     n_q, n_d;
  logic [ADDR_W:0] idx_q, idx_d;
  logic [7:0]      csum_q, csum_d;
  logic [7:0]      lo_q, lo_d;

  logic            accept;
  logic            wr_en;
  logic [ADDR_W:0] idx_inc;
  logic [15:0]     n_new;

  assign o_rxReady   = (state_q != RUN) && (state_q != ERROR);
  assign o_coreReset = (state_q != RUN);
  assign o_loadDone  = (state_q == RUN);
  assign o_loadError = (state_q == ERROR);

  assign accept  = i_rxValid && o_rxReady;
  assign n_new   = {i_rxByte, n_q[7:0]};
  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    lo_d    = lo_q;
    wr_en   = 1'b0;
    case (state_q)
      LEN_LO: if (accept) begin
        n_d     = {n_q[15:8], i_rxByte};
        csum_d  = csum_q ^ i_rxByte;
        state_d = LEN_HI;
      end
      LEN_HI: if (accept) begin
        n_d    = n_new;
        csum_d = csum_q ^ i_rxByte;
        // Exactly 2^ADDR_W words is a legal full-memory image.
        if (n_new == 16'h0000)             state_d = CHECK;
        else if ({1'b0, n_new} > DEPTH17)  state_d = ERROR;
        else                               state_d = DATA_LO;
      end
      DATA_LO: if (accept) begin
        lo_d    = i_rxByte;
        csum_d  = csum_q ^ i_rxByte;
        state_d = DATA_HI;
      end
      DATA_HI: if (accept) begin
        wr_en   = 1'b1;
        idx_d   = idx_inc;
        csum_d  = csum_q ^ i_rxByte;
        state_d = (17'(idx_inc) == {1'b0, n_q}) ? CHECK : DATA_LO;
      end
      CHECK: if (accept) begin
        state_d = (i_rxByte == csum_q) ? RUN : ERROR;
      end
      RUN, ERROR: if (i_loadReq) begin
        state_d = LEN_LO;
        n_d     = '0;
        idx_d   = '0;
        csum_d  = '0;
        lo_d    = '0;
      end
      default: state_d = LEN_LO;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= LEN_LO;
      n_q     <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      lo_q    <= lo_d;
    end
  end

  // Memory is deliberately outside the reset domain so images survive a core reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[idx_q[ADDR_W-1:0]] <= {i_rxByte, lo_q};
  end

  always_comb begin
    o_PMDATA = 16'h0000;
    if (state_q == RUN && {1'b0, i_PMADDR} < DEPTH17)
      o_PMDATA = mem[i_PMADDR[ADDR_W-1:0]];
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: image loads, checksum errors, length limits,
// throttled streams and mid-load reset.
module tb_prog_mem_loader;

  localparam int AW = 10;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [15:0] i_PMADDR = '0;
  logic [15:0] o_PMDATA;
  logic        i_rxValid = 1'b0;
  logic [7:0]  i_rxByte = '0;
  logic        o_rxReady;
  logic        i_loadReq = 1'b0;
  logic        o_coreReset, o_loadDone, o_loadError;

  prog_mem_loader #(.ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_PMADDR(i_PMADDR), .o_PMDATA(o_PMDATA),
    .i_rxValid(i_rxValid), .i_rxByte(i_rxByte), .o_rxReady(o_rxReady),
    .i_loadReq(i_loadReq), .o_coreReset(o_coreReset), .o_loadDone(o_loadDone),
    .o_loadError(o_loadError)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed { logic [15:0] a; logic [15:0] d; } sb_t;
  sb_t         sb_q[$];
  logic [15:0] mdl [int];
  logic [15:0] img[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic rdy, input logic crst,
                           input logic done, input logic err);
    chk({tag, ".rdy"},  16'(o_rxReady),   16'(rdy));
    chk({tag, ".crst"}, 16'(o_coreReset), 16'(crst));
    chk({tag, ".done"}, 16'(o_loadDone),  16'(done));
    chk({tag, ".err"},  16'(o_loadError), 16'(err));
  endtask

  // Present a byte from a falling edge and hold it through the accepting rising edge.
  task automatic send(input logic [7:0] b, input bit gap);
    int t = 0;
    @(negedge i_clk);
    i_rxValid = 1'b1;
    i_rxByte  = b;
    while (!o_rxReady && t < 20) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_rxReady) chk("send_timeout", 16'(o_rxReady), 16'd1);
    @(posedge i_clk);
    if (gap) begin
      @(negedge i_clk);
      i_rxValid = 1'b0;
      i_rxByte  = 8'hA5;
    end
  endtask

  task automatic load(input bit bad, input bit gap);
    logic [15:0] n;
    logic [7:0]  cs;
    n  = 16'(img.size());
    cs = n[7:0] ^ n[15:8];
    send(n[7:0], gap);
    send(n[15:8], gap);
    foreach (img[i]) begin
      send(img[i][7:0], gap);
      send(img[i][15:8], gap);
      cs ^= img[i][7:0] ^ img[i][15:8];
      mdl[i] = img[i];
    end
    send(bad ? (cs ^ 8'h01) : cs, 1'b0);
    @(negedge i_clk);
    i_rxValid = 1'b0;
    if (!bad) foreach (mdl[k]) sb_q.push_back({16'(k), mdl[k]});
  endtask

  task automatic check_reads();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(negedge i_clk);
      i_PMADDR = e.a;
      #1 chk($sformatf("rd[%0d]", e.a), o_PMDATA, e.d);
    end
  endtask

  task automatic req();
    @(negedge i_clk);
    i_loadReq = 1'b1;
    @(posedge i_clk);
    #1 i_loadReq = 1'b0;
    chk_flags("req", 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #3 chk_flags("in_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("in_rst.pm", o_PMDATA, 16'h0000);
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    #1 chk_flags("post_rst", 1'b1, 1'b1, 1'b0, 1'b0);

    // Basic two-word image, back-to-back bytes.
    img = {16'h1234, 16'h5678};
    load(1'b0, 1'b0);
    chk_flags("run1", 1'b0, 1'b0, 1'b1, 1'b0);
    check_reads();
    i_PMADDR = 16'h0400;
    #1 chk("oor400", o_PMDATA, 16'h0000);
    i_PMADDR = 16'hFFFF;
    #1 chk("oorFFFF", o_PMDATA, 16'h0000);

    // Same image, wrong checksum; bytes offered in ERROR must be ignored.
    req();
    load(1'b1, 1'b0);
    chk_flags("err1", 1'b0, 1'b1, 1'b0, 1'b1);
    i_PMADDR = 16'h0000;
    #1 chk("err1.pm", o_PMDATA, 16'h0000);
    @(negedge i_clk);
    i_rxValid = 1'b1;
    i_rxByte  = 8'h00;
    repeat (4) @(negedge i_clk);
    i_rxValid = 1'b0;
    chk_flags("err_hold", 1'b0, 1'b1, 1'b0, 1'b1);

    // Empty image: RUN with memory untouched.
    req();
    img = {};
    load(1'b0, 1'b0);
    chk_flags("run_n0", 1'b0, 1'b0, 1'b1, 1'b0);
    check_reads();

    // N = 1025 exceeds depth.
    req();
    send(8'h01, 1'b0);
    send(8'h04, 1'b0);
    @(negedge i_clk);
    i_rxValid = 1'b0;
    chk_flags("too_long", 1'b0, 1'b1, 1'b0, 1'b1);

    // Throttled stream (valid toggling every cycle).
    req();
    img = {16'hAAAA, 16'h5555, 16'h0F0F};
    load(1'b0, 1'b1);
    chk_flags("run_gap", 1'b0, 1'b0, 1'b1, 1'b0);
    check_reads();

    // Reset after three data bytes, then a one-word reload.
    req();
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    send(8'h11, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    mdl[0] = 16'h1111;
    #1 i_reset_n = 1'b0;
    i_rxValid = 1'b0;
    #1 chk_flags("mid_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mid_rst.pm", o_PMDATA, 16'h0000);
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    img = {16'hBEEF};
    load(1'b0, 1'b0);
    chk_flags("run_rst", 1'b0, 1'b0, 1'b1, 1'b0);
    check_reads();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
